// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, colour samples and timing lock from a 4-clk/pixel VGA stream.
// Optional per-frame CRC-16-CCITT of the sampled pixels when VGA_DEC_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        timing_error,
  output logic [15:0] frame_count
`ifdef VGA_DEC_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam logic [11:0] HC_PERIOD_LAST = 12'(H_TOTAL * 4 - 1);
  localparam logic [11:0] HC_SYNC_LAST   = 12'(H_SYNC * 4 - 1);
  localparam logic [9:0]  H_START        = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END          = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0]  V_START        = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END          = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [10:0] V_TOTAL_L      = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_L       = 11'(V_SYNC);

  typedef enum logic [1:0] {SEARCH, HSYNC_OK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [11:0] rgb_q;
  logic [11:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        good_q, good_d;
  logic        low_ok_q, low_ok_d;
  logic        vs_ok_q, vs_ok_d;
  logic        vc_valid_q, vc_valid_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        video_on_q, video_on_d, pix_valid_q, pix_valid_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        timing_error_q;
  logic [15:0] frame_count_q, frame_count_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] vc_inc;
  logic [9:0]  h;
  logic        active, mismatch, lock_next;

  assign hs_fall = hs_prev_q & ~hs_q;
  assign hs_rise = ~hs_prev_q & hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;
  assign vs_rise = ~vs_prev_q & vs_q;
  // Line count including a coincident hsync edge, so aligned and offset vsync edges measure alike.
  assign vc_inc  = {1'b0, vc_q} + {10'd0, hs_fall};
  assign h       = hc_q[11:2];
  assign active  = (h >= H_START) && (h < H_END) && (vc_q >= V_START) && (vc_q < V_END);

  always_comb begin
    mismatch = 1'b0;
    if (state_q != SEARCH) begin
      mismatch = (hs_fall && (hc_q != HC_PERIOD_LAST))
              || (hs_rise && (hc_q != HC_SYNC_LAST))
              || (vs_rise && vc_valid_q && (vc_inc != V_SYNC_L))
              || (vs_fall && vc_valid_q && (vc_inc != V_TOTAL_L))
              || ((state_q == LOCKED) && ((hc_q == 12'hFFF) || (vc_q == 10'h3FF)));
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (hs_fall) begin
          if ((hc_q == HC_PERIOD_LAST) && low_ok_q) begin
            if (good_q) begin
              state_d = HSYNC_OK;
              good_d  = 1'b0;
            end else begin
              good_d = 1'b1;
            end
          end else begin
            good_d = 1'b0;
          end
        end
      end
      HSYNC_OK: begin
        if (mismatch) state_d = SEARCH;
        else if (vs_fall && vc_valid_q && vs_ok_q) state_d = LOCKED;
      end
      LOCKED: begin
        if (mismatch) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    hc_d          = hs_fall ? 12'd0 : ((hc_q == 12'hFFF) ? hc_q : hc_q + 12'd1);
    vc_d          = vs_fall ? 10'd0 : ((hs_fall && (vc_q != 10'h3FF)) ? vc_q + 10'd1 : vc_q);
    low_ok_d      = hs_fall ? 1'b0 : (hs_rise ? (hc_q == HC_SYNC_LAST) : low_ok_q);
    vs_ok_d       = vs_fall ? 1'b0 : (vs_rise ? (vc_valid_q && (vc_inc == V_SYNC_L)) : vs_ok_q);
    vc_valid_d    = vs_fall ? 1'b1 : ((vc_q == 10'h3FF) ? 1'b0 : vc_valid_q);
    // Gate on the next state so video_on never outlives the cycle that drops lock.
    lock_next     = (state_d == LOCKED);
    video_on_d    = active && lock_next;
    pix_valid_d   = active && lock_next && (hc_q[1:0] == 2'd2);
    pix_rgb_d     = pix_valid_d ? rgb_q : pix_rgb_q;
    x_d           = active ? (h - H_START) : x_q;
    y_d           = active ? (vc_q - V_START) : y_q;
    frame_count_d = (vs_fall && (state_q == LOCKED) && !mismatch) ? frame_count_q + 16'd1
                                                                   : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SEARCH;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      hs_prev_q      <= 1'b1;
      vs_prev_q      <= 1'b1;
      rgb_q          <= 12'd0;
      hc_q           <= 12'd0;
      vc_q           <= 10'd0;
      good_q         <= 1'b0;
      low_ok_q       <= 1'b0;
      vs_ok_q        <= 1'b0;
      vc_valid_q     <= 1'b0;
      x_q            <= 10'd0;
      y_q            <= 10'd0;
      video_on_q     <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_rgb_q      <= 12'd0;
      timing_error_q <= 1'b0;
      frame_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      hs_q           <= hsync;
      vs_q           <= vsync;
      hs_prev_q      <= hs_q;
      vs_prev_q      <= vs_q;
      rgb_q          <= rgb;
      hc_q           <= hc_d;
      vc_q           <= vc_d;
      good_q         <= good_d;
      low_ok_q       <= low_ok_d;
      vs_ok_q        <= vs_ok_d;
      vc_valid_q     <= vc_valid_d;
      x_q            <= x_d;
      y_q            <= y_d;
      video_on_q     <= video_on_d;
      pix_valid_q    <= pix_valid_d;
      pix_rgb_q      <= pix_rgb_d;
      timing_error_q <= mismatch;
      frame_count_q  <= frame_count_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign video_on     = video_on_q;
  assign pix_valid    = pix_valid_q;
  assign pix_rgb      = pix_rgb_q;
  assign locked       = (state_q == LOCKED);
  assign timing_error = timing_error_q;
  assign frame_count  = frame_count_q;

`ifdef VGA_DEC_CRC_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_q, crc_upd, frame_crc_q;

  assign crc_upd = pix_valid_q ? crc16_step(crc_q, {4'h0, pix_rgb_q}) : crc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'd0;
    end else if (vs_fall) begin
      frame_crc_q <= crc_upd;
      crc_q       <= 16'hFFFF;
    end else begin
      crc_q <= crc_upd;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (20 px x 12 lines, 4 clk/px).
// Build with VGA_DEC_CRC_EN defined to also exercise the frame CRC.
module tb_vga_sync_decoder;

  localparam int LINE_CLK = 80;   // 20 px * 4 clk
  localparam int SHORT_CLK = 76;
  localparam int HS_LOW   = 16;   // 4 px sync
  localparam int LINES    = 12;
  localparam int VS_LINES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic [9:0]  x, y;
  logic        video_on, pix_valid, locked, timing_error;
  logic [11:0] pix_rgb;
  logic [15:0] frame_count;
`ifdef VGA_DEC_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_sync_decoder #(
    .H_TOTAL(20), .H_SYNC(4), .H_BP(2), .H_ACT(10),
    .V_TOTAL(12), .V_SYNC(2), .V_BP(2), .V_ACT(6)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x(x), .y(y), .video_on(video_on), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .locked(locked), .timing_error(timing_error), .frame_count(frame_count)
`ifdef VGA_DEC_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  // Generator pattern: one hot pixel (in generator pixel/line coordinates) over a background.
  int          hot_px = -1, hot_ln = -1;
  logic [11:0] hot_rgb = 12'h000, bg_rgb = 12'h000;

  // Cumulative observations taken on the falling edge.
  int          pv_total = 0, von_total = 0, err_total = 0, hot_total = 0;
  int          viol_von = 0, viol_lock = 0;
  logic [9:0]  hot_x = 10'd0, hot_y = 10'd0;
  logic [11:0] hot_c = 12'd0;
  logic        te_prev = 1'b0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pv_total <= pv_total + 1;
      if (pix_rgb != 12'h000) begin
        hot_total <= hot_total + 1;
        hot_x     <= x;
        hot_y     <= y;
        hot_c     <= pix_rgb;
      end
    end
    if (video_on) von_total <= von_total + 1;
    if (video_on && !locked) viol_von <= viol_von + 1;
    if (timing_error) err_total <= err_total + 1;
    if ((timing_error || te_prev) && locked) viol_lock <= viol_lock + 1;
    te_prev <= timing_error;
  end

  int n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic gen_cycle(input int line, input int c);
    hsync = (c < HS_LOW) ? 1'b0 : 1'b1;
    vsync = (line < VS_LINES) ? 1'b0 : 1'b1;
    rgb   = (line == hot_ln && (c / 4) == hot_px) ? hot_rgb : bg_rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int line, input int period);
    for (int c = 0; c < period; c++) gen_cycle(line, c);
  endtask

  task automatic drive_frame(input int short_line);
    for (int l = 0; l < LINES; l++) drive_line(l, (l == short_line) ? SHORT_CLK : LINE_CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_video_on"}, 32'(video_on), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_timing_error"}, 32'(timing_error), 32'd0);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

`ifdef VGA_DEC_CRC_EN
  function automatic logic [15:0] model_crc(input int n_words);
    logic [15:0] c;
    logic [15:0] w;
    c = 16'hFFFF;
    for (int k = 0; k < n_words; k++) begin
      w = 16'h0000;
      for (int b = 0; b < 16; b++) begin
        logic msb;
        msb = c[15] ^ w[15 - b];
        c = c << 1;
        if (msb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction
`endif

  typedef struct {
    int          px;
    int          ln;
    logic [11:0] color;
    int          exp_hits;
    int          exp_x;
    int          exp_y;
    int          exp_pix;
    int          exp_von;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   pv0, von0, hot0, err0;
`ifdef VGA_DEC_CRC_EN
    logic [15:0] crc_a;
`endif
    // generator px/line -> expected x,y (active px 6..15, lines 4..9)
    vecs[0] = '{px: 6,  ln: 4, color: 12'hF00, exp_hits: 1, exp_x: 0, exp_y: 0, exp_pix: 60, exp_von: 240};
    vecs[1] = '{px: 15, ln: 9, color: 12'h0AB, exp_hits: 1, exp_x: 9, exp_y: 5, exp_pix: 60, exp_von: 240};
    vecs[2] = '{px: 9,  ln: 6, color: 12'hFFF, exp_hits: 1, exp_x: 3, exp_y: 2, exp_pix: 60, exp_von: 240};
    vecs[3] = '{px: 15, ln: 4, color: 12'h001, exp_hits: 1, exp_x: 9, exp_y: 0, exp_pix: 60, exp_von: 240};
    vecs[4] = '{px: 6,  ln: 9, color: 12'h800, exp_hits: 1, exp_x: 0, exp_y: 5, exp_pix: 60, exp_von: 240};
    vecs[5] = '{px: 5,  ln: 4, color: 12'hF0F, exp_hits: 0, exp_x: 0, exp_y: 0, exp_pix: 60, exp_von: 240};
    vecs[6] = '{px: 16, ln: 9, color: 12'h0F0, exp_hits: 0, exp_x: 0, exp_y: 0, exp_pix: 60, exp_von: 240};
    vecs[7] = '{px: 10, ln: 3, color: 12'h123, exp_hits: 0, exp_x: 0, exp_y: 0, exp_pix: 60, exp_von: 240};

    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Acquisition: first frame finds hsync, second vsync edge locks.
    drive_frame(-1);
    check("lock_after_frame1", 32'(locked), 32'd0);
    drive_frame(-1);
    check("lock_after_frame2", 32'(locked), 32'd1);
    check("fcount_after_frame2", 32'(frame_count), 32'd0);

    for (int i = 0; i < 8; i++) begin
      hot_px = vecs[i].px; hot_ln = vecs[i].ln; hot_rgb = vecs[i].color;
      pv0 = pv_total; von0 = von_total; hot0 = hot_total; err0 = err_total;
      drive_frame(-1);
      check($sformatf("v%0d_hits", i), 32'(hot_total - hot0), 32'(vecs[i].exp_hits));
      if (vecs[i].exp_hits == 1) begin
        check($sformatf("v%0d_x", i), 32'(hot_x), 32'(vecs[i].exp_x));
        check($sformatf("v%0d_y", i), 32'(hot_y), 32'(vecs[i].exp_y));
        check($sformatf("v%0d_rgb", i), 32'(hot_c), 32'(vecs[i].color));
      end
      check($sformatf("v%0d_pix_count", i), 32'(pv_total - pv0), 32'(vecs[i].exp_pix));
      check($sformatf("v%0d_video_on_cycles", i), 32'(von_total - von0), 32'(vecs[i].exp_von));
      check($sformatf("v%0d_x_hold", i), 32'(x), 32'd9);
      check($sformatf("v%0d_y_hold", i), 32'(y), 32'd5);
      check($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(i + 1));
      check($sformatf("v%0d_errors", i), 32'(err_total - err0), 32'd0);
    end
    hot_px = -1; hot_ln = -1; hot_rgb = 12'h000;

`ifdef VGA_DEC_CRC_EN
    drive_frame(-1);
    drive_frame(-1);
    check("crc_frame_a", 32'(frame_crc), 32'(model_crc(60)));
    crc_a = frame_crc;
    drive_frame(-1);
    check("crc_frame_b_same", 32'(frame_crc), 32'(crc_a));
`endif

    // One short line while locked.
    err0 = err_total;
    drive_frame(5);
    check("short_line_err_pulses", 32'(err_total - err0), 32'd1);
    check("short_line_unlocked", 32'(locked), 32'd0);
    drive_frame(-1);
    check("short_line_relock", 32'(locked), 32'd1);
    check("short_line_err_total", 32'(err_total - err0), 32'd1);

    // hsync stuck high long enough to saturate the clk counter.
    err0 = err_total;
    for (int l = 0; l < 5; l++) drive_line(l, LINE_CLK);
    hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
    repeat (5000) @(posedge clk);
    #1;
    check("stuck_err_pulses", 32'(err_total - err0), 32'd1);
    check("stuck_unlocked", 32'(locked), 32'd0);
    drive_frame(-1);
    check("stuck_resume1_unlocked", 32'(locked), 32'd0);
    drive_frame(-1);
    check("stuck_resume2_locked", 32'(locked), 32'd1);
    check("stuck_err_total", 32'(err_total - err0), 32'd1);

    // Reset pulse mid-frame in the active region.
    bg_rgb = 12'h123;
    err0 = err_total;
    for (int l = 0; l < 7; l++) drive_line(l, LINE_CLK);
    for (int c = 0; c < 40; c++) gen_cycle(7, c);
    check("pre_reset_locked", 32'(locked), 32'd1);
    check("pre_reset_video_on", 32'(video_on), 32'd1);
    check("pre_reset_pix_rgb", 32'(pix_rgb), 32'h123);
    reset = 1'b1;
    gen_cycle(7, 40);
    check_all_zero("midreset");
    reset = 1'b0;
    for (int c = 41; c < LINE_CLK; c++) gen_cycle(7, c);
    for (int l = 8; l < LINES; l++) drive_line(l, LINE_CLK);
    check("midreset_tail_unlocked", 32'(locked), 32'd0);
    drive_frame(-1);
    check("midreset_frameX_unlocked", 32'(locked), 32'd0);
    drive_frame(-1);
    check("midreset_frameY_locked", 32'(locked), 32'd1);
    check("midreset_fcount", 32'(frame_count), 32'd0);
    check("midreset_no_err", 32'(err_total - err0), 32'd0);

    check("video_on_without_lock", 32'(viol_von), 32'd0);
    check("locked_around_error", 32'(viol_lock), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
